// File: rtl/fifo_bh_sync_width_conv_almost_full_if.sv
// Push/pop bus of the width-converting FIFO: producer/consumer side is master, FIFO is slave.
interface fifo_bh_sync_width_conv_almost_full_if #(
  parameter int WR_WIDTH  = 32,
  parameter int RD_WIDTH  = 32,
  parameter int DEPTH_LG2 = 4
);
  logic                 flush_i;
  logic                 wren_i;
  logic [WR_WIDTH-1:0]  wdata_i;
  logic                 full_o;
  logic                 almost_full_o;
  logic                 rden_i;
  logic [RD_WIDTH-1:0]  rdata_o;
  logic                 empty_o;
  logic                 valid_o;
  logic [DEPTH_LG2:0]   count_o;
  logic                 overflow_o;
  logic                 underflow_o;

  modport master (
    output flush_i, wren_i, wdata_i, rden_i,
    input  full_o, almost_full_o, rdata_o, empty_o, valid_o, count_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, wren_i, wdata_i, rden_i,
    output full_o, almost_full_o, rdata_o, empty_o, valid_o, count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_bh_sync_width_conv_almost_full.sv
// Single-clock FWFT FIFO packing/unpacking between write and read widths; write-to-valid 1 clk, read 0 clk.
// Writes are refused while full_o and reads while empty_o, using flags registered at cycle start.
module fifo_bh_sync_width_conv_almost_full #(
  parameter int WR_WIDTH          = 32,
  parameter int RD_WIDTH          = 32,
  parameter int DEPTH_LG2         = 4,
  parameter int ALMOST_FULL_SPACE = 2
) (
  input logic clk,
  input logic reset_n,
  fifo_bh_sync_width_conv_almost_full_if.slave bus
);

  localparam int NW        = (WR_WIDTH < RD_WIDTH) ? WR_WIDTH : RD_WIDTH;
  localparam int WR_RATIO  = WR_WIDTH / NW;
  localparam int RD_RATIO  = RD_WIDTH / NW;
  localparam int MAX_RATIO = (WR_RATIO > RD_RATIO) ? WR_RATIO : RD_RATIO;
  localparam int DEPTH     = 1 << DEPTH_LG2;
  localparam int PW        = DEPTH_LG2;
  localparam int CW        = DEPTH_LG2 + 1;

  localparam logic [CW-1:0] WR_INC    = CW'(WR_RATIO);
  localparam logic [CW-1:0] RD_DEC    = CW'(RD_RATIO);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam bit            AF_RST    = (DEPTH / WR_RATIO) < ALMOST_FULL_SPACE;

  function automatic bit ratio_ok(input int r);
    return (r == 1) || (r == 2) || (r == 4) || (r == 8);
  endfunction

  generate
    if (!ratio_ok(WR_RATIO) || !ratio_ok(RD_RATIO) ||
        (WR_WIDTH % NW) != 0 || (RD_WIDTH % NW) != 0 ||
        DEPTH < 2 * MAX_RATIO) begin : g_bad_cfg
      $error("fifo_bh_sync_width_conv_almost_full: unsupported width ratio or depth");
    end
  endgenerate

  logic [NW-1:0]       mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_nxt;
  logic [CW-1:0]       free_nxt;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic                overflow;
  logic                underflow;
  logic                acc_wr;
  logic                acc_rd;
  logic [RD_WIDTH-1:0] rdata;

  assign acc_wr = bus.wren_i & ~full;
  assign acc_rd = bus.rden_i & ~empty;

  always_comb begin
    count_nxt = count;
    if (acc_wr) count_nxt = count_nxt + WR_INC;
    if (acc_rd) count_nxt = count_nxt - RD_DEC;
    free_nxt = DEPTH_CNT - count_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= AF_RST;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (bus.flush_i) begin
      // flush empties the buffer but keeps the sticky error history
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= AF_RST;
    end else begin
      if (acc_wr) wr_ptr <= wr_ptr + PW'(WR_RATIO);
      if (acc_rd) rd_ptr <= rd_ptr + PW'(RD_RATIO);
      count       <= count_nxt;
      full        <= free_nxt < WR_INC;
      empty       <= count_nxt < RD_DEC;
      almost_full <= (32'(free_nxt) / 32'(WR_RATIO)) < 32'(ALMOST_FULL_SPACE);
      overflow    <= overflow  | (bus.wren_i & full);
      underflow   <= underflow | (bus.rden_i & empty);
    end
  end

  // storage is deliberately not reset; only pointers define what is live
  always_ff @(posedge clk) begin
    if (reset_n && !bus.flush_i && acc_wr) begin
      for (int k = 0; k < WR_RATIO; k++) begin
        mem[wr_ptr + PW'(k)] <= bus.wdata_i[k*NW +: NW];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < RD_RATIO; k++) begin
      rdata[k*NW +: NW] = mem[rd_ptr + PW'(k)];
    end
  end

  assign bus.rdata_o       = rdata;
  assign bus.full_o        = full;
  assign bus.almost_full_o = almost_full;
  assign bus.empty_o       = empty;
  assign bus.valid_o       = ~empty;
  assign bus.count_o       = count;
  assign bus.overflow_o    = overflow;
  assign bus.underflow_o   = underflow;

endmodule

// File: tb/tb_fifo_bh_sync_width_conv_almost_full.sv
// Scoreboard bench for the width-converting FIFO: 32->8, 8->32 and 32->32 instances on one clock.
module tb_fifo_bh_sync_width_conv_almost_full;

  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_bh_sync_width_conv_almost_full_if #(.WR_WIDTH(32), .RD_WIDTH(8),  .DEPTH_LG2(4)) b1 ();
  fifo_bh_sync_width_conv_almost_full_if #(.WR_WIDTH(8),  .RD_WIDTH(32), .DEPTH_LG2(4)) b2 ();
  fifo_bh_sync_width_conv_almost_full_if #(.WR_WIDTH(32), .RD_WIDTH(32), .DEPTH_LG2(4)) b3 ();

  fifo_bh_sync_width_conv_almost_full #(.WR_WIDTH(32), .RD_WIDTH(8),  .DEPTH_LG2(4), .ALMOST_FULL_SPACE(2))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));
  fifo_bh_sync_width_conv_almost_full #(.WR_WIDTH(8),  .RD_WIDTH(32), .DEPTH_LG2(4), .ALMOST_FULL_SPACE(2))
    dut2 (.clk(clk), .reset_n(reset_n), .bus(b2));
  fifo_bh_sync_width_conv_almost_full #(.WR_WIDTH(32), .RD_WIDTH(32), .DEPTH_LG2(4), .ALMOST_FULL_SPACE(2))
    dut3 (.clk(clk), .reset_n(reset_n), .bus(b3));

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] q1 [$];
  logic [31:0] q2 [$];
  logic [31:0] q3 [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr3(input logic [31:0] d);
    b3.wdata_i = d;
    b3.wren_i  = 1'b1;
    q3.push_back(d);
    tick();
    b3.wren_i  = 1'b0;
  endtask

  task automatic drain3(input string tag);
    int guard;
    guard = 0;
    while (b3.valid_o && guard < 40) begin
      if (q3.size() == 0) begin
        check({tag, "_extra_word"}, 64'd1, 64'd0);
        break;
      end
      check(tag, b3.rdata_o, q3.pop_front());
      b3.rden_i = 1'b1;
      tick();
      guard++;
    end
    b3.rden_i = 1'b0;
    check({tag, "_left"}, q3.size(), 0);
    check({tag, "_empty"}, b3.empty_o, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int guard;
    reset_n = 1'b0;
    b1.flush_i = 0; b1.wren_i = 0; b1.rden_i = 0; b1.wdata_i = '0;
    b2.flush_i = 0; b2.wren_i = 0; b2.rden_i = 0; b2.wdata_i = '0;
    b3.flush_i = 0; b3.wren_i = 0; b3.rden_i = 0; b3.wdata_i = '0;
    tick();
    tick();
    reset_n = 1'b1;

    check("rst_count",     b3.count_o,       0);
    check("rst_empty",     b3.empty_o,       1'b1);
    check("rst_valid",     b3.valid_o,       1'b0);
    check("rst_full",      b3.full_o,        1'b0);
    check("rst_afull",     b3.almost_full_o, 1'b0);
    check("rst_overflow",  b3.overflow_o,    1'b0);
    check("rst_underflow", b3.underflow_o,   1'b0);
    check("rst_empty_b1",  b1.empty_o,       1'b1);
    check("rst_afull_b1",  b1.almost_full_o, 1'b0);
    check("rst_empty_b2",  b2.empty_o,       1'b1);

    // 32 -> 8 unpacking, little-endian byte order
    b1.wdata_i = 32'h4433_2211;
    b1.wren_i  = 1'b1;
    q1.push_back(32'h11); q1.push_back(32'h22); q1.push_back(32'h33); q1.push_back(32'h44);
    tick();
    b1.wren_i = 1'b0;
    check("t1_valid", b1.valid_o,       1'b1);
    check("t1_count", b1.count_o,       4);
    check("t1_afull", b1.almost_full_o, 1'b0);
    guard = 0;
    while (b1.valid_o && q1.size() > 0 && guard < 8) begin
      check("t1_rdata", b1.rdata_o, q1.pop_front());
      b1.rden_i = 1'b1;
      tick();
      guard++;
    end
    b1.rden_i = 1'b0;
    check("t1_left",  q1.size(), 0);
    check("t1_empty", b1.empty_o, 1'b1);
    check("t1_count0", b1.count_o, 0);

    // 8 -> 32 packing: no read word until four bytes are stored
    b2.wren_i = 1'b1;
    b2.wdata_i = 8'hA1; tick(); check("t2_empty_1", b2.empty_o, 1'b1);
    b2.wdata_i = 8'hB2; tick(); check("t2_empty_2", b2.empty_o, 1'b1);
    b2.wdata_i = 8'hC3; tick(); check("t2_empty_3", b2.empty_o, 1'b1);
    b2.wdata_i = 8'hD4;
    q2.push_back(32'hD4C3_B2A1);
    tick();
    b2.wren_i = 1'b0;
    check("t2_valid", b2.valid_o, 1'b1);
    check("t2_count", b2.count_o, 4);
    check("t2_rdata", b2.rdata_o, q2.pop_front());
    b2.rden_i = 1'b1;
    tick();
    b2.rden_i = 1'b0;
    check("t2_empty_after", b2.empty_o, 1'b1);

    // fill to full, watching almost_full = (16 - count) < 2
    for (int i = 1; i <= 16; i++) begin
      wr3(32'h1000_0000 + 32'(i));
      check("t3_count", b3.count_o, i);
      check("t3_afull", b3.almost_full_o, (16 - i) < 2);
      check("t3_full",  b3.full_o, i == 16);
    end
    b3.wdata_i = 32'hDEAD_BEEF;
    b3.wren_i  = 1'b1;
    b3.rden_i  = 1'b1;
    check("t3_head", b3.rdata_o, q3.pop_front());
    tick();
    b3.wren_i = 1'b0;
    b3.rden_i = 1'b0;
    check("t3_overflow", b3.overflow_o, 1'b1);
    check("t3_count15",  b3.count_o, 15);
    check("t3_full_clr", b3.full_o, 1'b0);
    check("t3_afull15",  b3.almost_full_o, 1'b1);
    drain3("t3_rdata");

    // steady state: simultaneous push/pop across pointer wrap
    for (int i = 0; i < 8; i++) wr3($urandom);
    check("t4_count_start", b3.count_o, 8);
    for (int i = 0; i < 40; i++) begin
      check("t4_rdata", b3.rdata_o, q3.pop_front());
      d = $urandom;
      q3.push_back(d);
      b3.wdata_i = d;
      b3.wren_i  = 1'b1;
      b3.rden_i  = 1'b1;
      tick();
      check("t4_count", b3.count_o, 8);
    end
    b3.wren_i = 1'b0;
    b3.rden_i = 1'b0;
    drain3("t4_drain");

    // underflow is sticky and survives a flush
    check("t5_underflow_pre", b3.underflow_o, 1'b0);
    b3.rden_i = 1'b1;
    tick();
    b3.rden_i = 1'b0;
    check("t5_underflow", b3.underflow_o, 1'b1);
    check("t5_count0",    b3.count_o, 0);
    for (int i = 0; i < 6; i++) wr3(32'hF000_0000 + 32'(i));
    check("t5_count6", b3.count_o, 6);
    b3.flush_i = 1'b1;
    tick();
    b3.flush_i = 1'b0;
    q3.delete();
    check("t5_flush_count", b3.count_o, 0);
    check("t5_flush_empty", b3.empty_o, 1'b1);
    check("t5_flush_under", b3.underflow_o, 1'b1);
    check("t5_flush_over",  b3.overflow_o, 1'b1);

    // reset mid-stream discards contents and clears sticky flags
    for (int i = 0; i < 9; i++) wr3(32'hA000_0000 + 32'(i));
    check("t6_count9", b3.count_o, 9);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    q3.delete();
    check("t6_count",     b3.count_o, 0);
    check("t6_empty",     b3.empty_o, 1'b1);
    check("t6_valid",     b3.valid_o, 1'b0);
    check("t6_full",      b3.full_o, 1'b0);
    check("t6_afull",     b3.almost_full_o, 1'b0);
    check("t6_overflow",  b3.overflow_o, 1'b0);
    check("t6_underflow", b3.underflow_o, 1'b0);
    wr3(32'hCAFE_F00D);
    check("t6_valid_after", b3.valid_o, 1'b1);
    check("t6_count1",      b3.count_o, 1);
    drain3("t6_rdata");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
